// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a program-load write port, and the IF/ID pipeline register.
// Priority each cycle: reset > redirect (flush) > stall (hold) > normal fetch.
module if_stage_fetch #(
  parameter int XLEN = 32,
  parameter int IMEM_AW = 6,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [XLEN-1:0]    prog_data,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [XLEN-1:0]    if_id_instr,
  output logic               if_id_valid
);

  localparam int DEPTH = 1 << IMEM_AW;

  // Instruction storage; deliberately not cleared by reset so a loaded
  // program survives a core restart.
  logic [XLEN-1:0]    imem_r [DEPTH];

  logic [IMEM_AW-1:0] fetch_idx_s;
  logic [XLEN-1:0]    fetch_word_s;
  logic [XLEN-1:0]    pc_seq_s;
  logic [XLEN-1:0]    redirect_target_s;

  // PC bits above the memory index are ignored, so fetches alias/wrap.
  assign fetch_idx_s       = pc_out[IMEM_AW+1:2];
  assign fetch_word_s      = imem_r[fetch_idx_s];
  assign pc_seq_s          = pc_out + XLEN'(4);
  // Misaligned redirect targets are silently word-aligned.
  assign redirect_target_s = redirect_pc & ~(XLEN'(3));

  // Program-load write port; the fetch in the same cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem_r[prog_addr] <= prog_data;
    end
  end

  // PC and IF/ID register update with reset > redirect > stall > fetch priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= RESET_PC;
      if_id_pc    <= XLEN'(0);
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc_out      <= redirect_target_s;
      if_id_pc    <= XLEN'(0);
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc_out      <= pc_out;
      if_id_pc    <= if_id_pc;
      if_id_instr <= if_id_instr;
      if_id_valid <= if_id_valid;
    end else begin
      pc_out      <= pc_seq_s;
      if_id_pc    <= pc_out;
      if_id_instr <= fetch_word_s;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: directed scenarios with constant
// expectations, then randomized traffic checked against a behavioural model.
module tb_if_stage_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int n_checks;
  int n_fail;

  // Behavioural model state
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_valid;
  } step_t;

  if_stage_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pc_out(pc_out), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(logic rst, logic stl, logic rdr, logic [31:0] rpc,
                               logic we, logic [5:0] wa, logic [31:0] wd,
                               logic [31:0] e_pc, logic [31:0] e_ipc,
                               logic [31:0] e_instr, logic e_valid);
    step_t s;
    s.rst = rst; s.stl = stl; s.rdr = rdr; s.rpc = rpc;
    s.we = we; s.wa = wa; s.wd = wd;
    s.e_pc = e_pc; s.e_ipc = e_ipc; s.e_instr = e_instr; s.e_valid = e_valid;
    return s;
  endfunction

  // Next-state rules of the fetch stage, evaluated on the inputs present at the edge.
  task automatic model_step();
    logic [31:0] fetched;
    fetched = m_mem[(m_pc / 32'd4) % 32'd64];
    if (reset) begin
      m_pc = 32'd0; m_ipc = 32'd0; m_instr = 32'h13; m_valid = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc - (redirect_pc % 32'd4);
      m_ipc = 32'd0; m_instr = 32'h13; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = fetched; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(step_t s);
    reset = s.rst; stall = s.stl; redirect = s.rdr; redirect_pc = s.rpc;
    prog_we = s.we; prog_addr = s.wa; prog_data = s.wd;
  endtask

  task automatic test_reset();
    // Hold reset while loading the whole memory.
    for (int i = 0; i < 64; i++) begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      prog_we = 1'b1; prog_addr = 6'(i);
      case (i)
        0: prog_data = 32'h11;
        1: prog_data = 32'h22;
        2: prog_data = 32'h33;
        3: prog_data = 32'h44;
        63: prog_data = 32'hAA;
        default: prog_data = $urandom;
      endcase
      tick();
    end
    prog_we = 1'b0; reset = 1'b0;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc: got %h want %h", if_id_pc, 32'h0); end
    n_checks++; if (if_id_instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h13); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
  endtask

  task automatic test_fetch();
    step_t q[$];
    q.push_back(mk(0,0,0,0, 0,0,0, 32'h4, 32'h0, 32'h11, 1));
    q.push_back(mk(0,0,0,0, 0,0,0, 32'h8, 32'h4, 32'h22, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL fetch[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_stall();
    step_t q[$];
    for (int k = 0; k < 3; k++) q.push_back(mk(0,1,0,0, 0,0,0, 32'h8, 32'h4, 32'h22, 1));
    q.push_back(mk(0,0,0,0, 0,0,0, 32'hC, 32'h8, 32'h33, 1));
    q.push_back(mk(0,0,0,0, 0,0,0, 32'h10, 32'hC, 32'h44, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_t q[$];
    q.push_back(mk(1,0,0,0, 0,0,0, 32'h0, 32'h0, 32'h13, 0));
    q.push_back(mk(0,0,0,0, 0,0,0, 32'h4, 32'h0, 32'h11, 1));
    q.push_back(mk(0,0,0,0, 0,0,0, 32'h8, 32'h4, 32'h22, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_redirect();
    step_t q[$];
    q.push_back(mk(0,1,1,32'h6, 0,0,0, 32'h4, 32'h0, 32'h13, 0));
    q.push_back(mk(0,0,0,0,     0,0,0, 32'h8, 32'h4, 32'h22, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_collision();
    step_t q[$];
    q.push_back(mk(0,0,0,0,    1,6'd2,32'h99, 32'hC, 32'h8, 32'h33, 1));
    q.push_back(mk(0,0,1,32'h8, 0,0,0,        32'h8, 32'h0, 32'h13, 0));
    q.push_back(mk(0,0,0,0,    0,0,0,         32'hC, 32'h8, 32'h99, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL collision[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_wrap();
    step_t q[$];
    q.push_back(mk(0,0,1,32'hFFFF_FFFC, 0,0,0, 32'hFFFF_FFFC, 32'h0,         32'h13, 0));
    q.push_back(mk(0,0,0,0,             0,0,0, 32'h0,         32'hFFFF_FFFC, 32'hAA, 1));
    q.push_back(mk(0,0,0,0,             0,0,0, 32'h4,         32'h0,         32'h11, 1));
    foreach (q[i]) begin
      drive(q[i]); tick();
      n_checks++;
      if (pc_out !== q[i].e_pc || if_id_pc !== q[i].e_ipc || if_id_instr !== q[i].e_instr || if_id_valid !== q[i].e_valid) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, q[i].e_pc, q[i].e_ipc, q[i].e_instr, q[i].e_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      redirect    = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_pc = $urandom;
      prog_we     = ($urandom_range(0, 5) == 0);
      prog_addr   = 6'($urandom_range(0, 63));
      prog_data   = $urandom;
      tick();
      n_checks++;
      if (pc_out !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_instr || if_id_valid !== m_valid) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=%h ipc=%h instr=%h v=%b", i,
                 pc_out, if_id_pc, if_id_instr, if_id_valid, m_pc, m_ipc, m_instr, m_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_pc = 32'd0; m_ipc = 32'd0; m_instr = 32'h13; m_valid = 1'b0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    prog_we = 1'b0; prog_addr = 6'd0; prog_data = 32'd0;
    test_reset();
    test_fetch();
    test_stall();
    test_mid_reset();
    test_redirect();
    test_collision();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
